// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined control unit: instruction encodings,
// ALU operation codes, control-word bit layout and the SYSCALL FSM states.
package ctrl_pkg;

  localparam int CTRL_W = 19;

  // Control-word bit offsets, LSB first
  localparam int F_ALU_OP     = 0;
  localparam int F_ALU_SRC    = 4;
  localparam int F_REG_WRITE  = 5;
  localparam int F_MEM_TO_REG = 6;
  localparam int F_MEM_WRITE  = 7;
  localparam int F_LB         = 8;
  localparam int F_SIGNED_EXT = 9;
  localparam int F_REG_DST    = 10;
  localparam int F_BEQ        = 11;
  localparam int F_BNE        = 12;
  localparam int F_BLTZ       = 13;
  localparam int F_JMP        = 14;
  localparam int F_JAL        = 15;
  localparam int F_JR         = 16;
  localparam int F_SRAV       = 17;
  localparam int F_SYSCALL    = 18;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS decoder: instruction word to packed control word plus
// the architectural destination register.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [4:0]        dst_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_fields;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  // rs and shamt do not influence the control word
  assign unused_fields = ^{instr_i[25:21], instr_i[10:6]};

  always_comb begin
    ctrl_o = '0;
    case (op)
      OP_RTYPE: begin
        ctrl_o[F_REG_WRITE] = 1'b1;
        ctrl_o[F_REG_DST]   = 1'b1;
        case (funct)
          FN_ADD:  ctrl_o[F_ALU_OP +: 4] = ALU_ADD;
          FN_ADDU: ctrl_o[F_ALU_OP +: 4] = ALU_ADDU;
          FN_SUB:  ctrl_o[F_ALU_OP +: 4] = ALU_SUB;
          FN_AND:  ctrl_o[F_ALU_OP +: 4] = ALU_AND;
          FN_OR:   ctrl_o[F_ALU_OP +: 4] = ALU_OR;
          FN_NOR:  ctrl_o[F_ALU_OP +: 4] = ALU_NOR;
          FN_SLT:  ctrl_o[F_ALU_OP +: 4] = ALU_SLT;
          FN_SLTU: ctrl_o[F_ALU_OP +: 4] = ALU_SLTU;
          FN_SLL:  ctrl_o[F_ALU_OP +: 4] = ALU_SLL;
          FN_SRL:  ctrl_o[F_ALU_OP +: 4] = ALU_SRL;
          FN_SRA:  ctrl_o[F_ALU_OP +: 4] = ALU_SRA;
          FN_SRAV: begin
            ctrl_o[F_ALU_OP +: 4] = ALU_SRA;
            ctrl_o[F_SRAV]        = 1'b1;
          end
          FN_JR: begin
            ctrl_o       = '0;
            ctrl_o[F_JR] = 1'b1;
          end
          FN_SYSCALL: begin
            ctrl_o            = '0;
            ctrl_o[F_SYSCALL] = 1'b1;
          end
          default: ctrl_o = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI: begin
        ctrl_o[F_ALU_SRC]    = 1'b1;
        ctrl_o[F_REG_WRITE]  = 1'b1;
        ctrl_o[F_SIGNED_EXT] = 1'b1;
        ctrl_o[F_ALU_OP +: 4] = (op == OP_ADDI)  ? ALU_ADD :
                                (op == OP_ADDIU) ? ALU_ADDU : ALU_SLT;
      end
      OP_ANDI, OP_ORI: begin
        ctrl_o[F_ALU_SRC]     = 1'b1;
        ctrl_o[F_REG_WRITE]   = 1'b1;
        ctrl_o[F_ALU_OP +: 4] = (op == OP_ANDI) ? ALU_AND : ALU_OR;
      end
      OP_LW, OP_LB: begin
        ctrl_o[F_ALU_SRC]    = 1'b1;
        ctrl_o[F_REG_WRITE]  = 1'b1;
        ctrl_o[F_MEM_TO_REG] = 1'b1;
        ctrl_o[F_SIGNED_EXT] = 1'b1;
        ctrl_o[F_LB]         = (op == OP_LB);
      end
      OP_SW: begin
        ctrl_o[F_ALU_SRC]    = 1'b1;
        ctrl_o[F_MEM_WRITE]  = 1'b1;
        ctrl_o[F_SIGNED_EXT] = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o[F_BEQ]         = 1'b1;
        ctrl_o[F_ALU_OP +: 4] = ALU_SUB;
      end
      OP_BNE: begin
        ctrl_o[F_BNE]         = 1'b1;
        ctrl_o[F_ALU_OP +: 4] = ALU_SUB;
      end
      OP_BLTZ: ctrl_o[F_BLTZ] = 1'b1;
      OP_J:    ctrl_o[F_JMP]  = 1'b1;
      OP_JAL: begin
        ctrl_o[F_JAL]       = 1'b1;
        ctrl_o[F_REG_WRITE] = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

  assign dst_o = ctrl_o[F_JAL]     ? 5'd31 :
                 ctrl_o[F_REG_DST] ? instr_i[15:11] : instr_i[20:16];

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID register, STAGES control-word stages, load-use
// stall, branch flush and the SYSCALL drain/halt state machine.
module pipe_ctrl_unit #(
  parameter int STAGES = 3,
  parameter int CTRL_W = ctrl_pkg::CTRL_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       Instr,
  input  logic              IfValid,
  output logic              Ready,
  input  logic              BranchTaken,
  input  logic              Go,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [CTRL_W-1:0] MEM_Ctrl,
  output logic [CTRL_W-1:0] WB_Ctrl,
  output logic              EX_Valid,
  output logic              MEM_Valid,
  output logic              WB_Valid,
  output logic [4:0]        WB_Dst,
  output logic              Halted
);

  import ctrl_pkg::*;

  state_e            state_q, state_d;
  logic              id_valid_q, id_valid_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_dst;

  logic [CTRL_W-1:0] ctrl_q [1:STAGES];
  logic [4:0]        dst_q  [1:STAGES];
  logic [STAGES:1]   valid_q;

  logic hazard, id_uses_rt, id_advance, id_is_sys, accept;

  ctrl_decode u_decode (
    .instr_i (id_instr_q),
    .ctrl_o  (id_ctrl),
    .dst_o   (id_dst)
  );

  assign id_uses_rt = (id_instr_q[31:26] == OP_RTYPE) | id_ctrl[F_MEM_WRITE] |
                      id_ctrl[F_BEQ] | id_ctrl[F_BNE];
  assign hazard = id_valid_q & valid_q[1] & ctrl_q[1][F_MEM_TO_REG] &
                  (dst_q[1] != 5'd0) &
                  ((dst_q[1] == id_instr_q[25:21]) |
                   (id_uses_rt & (dst_q[1] == id_instr_q[20:16])));
  assign id_advance = id_valid_q & ~hazard & ~BranchTaken;
  assign id_is_sys  = id_valid_q & id_ctrl[F_SYSCALL];
  assign accept     = IfValid & Ready & ~BranchTaken;

  always_comb begin
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    if (BranchTaken) begin
      id_valid_d = 1'b0;
    end else if (accept) begin
      id_valid_d = 1'b1;
      id_instr_d = Instr;
    end else if (!hazard) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      state_q    <= RUN;
    end else begin
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      state_q    <= state_d;
    end
  end

  // Nothing is fetched behind a SYSCALL sitting in ID, so the drain starts clean
  always_comb begin
    state_d = state_q;
    Ready   = 1'b0;
    Halted  = 1'b0;
    case (state_q)
      RUN: begin
        Ready = ~hazard & ~id_is_sys;
        if (id_advance && id_ctrl[F_SYSCALL]) state_d = DRAIN;
      end
      DRAIN: begin
        if (valid_q == '0 && !id_valid_q) state_d = HALT;
      end
      HALT: begin
        Halted = 1'b1;
        if (Go) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  for (genvar gi = 1; gi <= STAGES; gi++) begin : gen_stage
    if (gi == 1) begin : gen_ex
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          valid_q[gi] <= 1'b0;
          ctrl_q[gi]  <= '0;
          dst_q[gi]   <= '0;
        end else begin
          valid_q[gi] <= id_advance;
          ctrl_q[gi]  <= id_advance ? id_ctrl : '0;
          dst_q[gi]   <= id_advance ? id_dst : 5'd0;
        end
      end
    end else begin : gen_tail
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          valid_q[gi] <= 1'b0;
          ctrl_q[gi]  <= '0;
          dst_q[gi]   <= '0;
        end else begin
          valid_q[gi] <= valid_q[gi-1];
          ctrl_q[gi]  <= ctrl_q[gi-1];
          dst_q[gi]   <= dst_q[gi-1];
        end
      end
    end
  end

  assign EX_Ctrl   = ctrl_q[1];
  assign MEM_Ctrl  = ctrl_q[2];
  assign WB_Ctrl   = ctrl_q[STAGES];
  assign EX_Valid  = valid_q[1];
  assign MEM_Valid = valid_q[2];
  assign WB_Valid  = valid_q[STAGES];
  assign WB_Dst    = dst_q[STAGES];

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit with a 3-stage and a 6-stage instance
// driven from the same stimulus.
module tb_pipe_ctrl_unit;

  localparam logic [31:0] ADD3  = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] ADD6  = 32'h00A2_3020; // add $6,$5,$2
  localparam logic [31:0] LW5   = 32'h8C25_0000; // lw  $5,0($1)
  localparam logic [31:0] ORI5  = 32'h3405_0001; // ori $5,$0,1
  localparam logic [31:0] ORI8  = 32'h3408_0055; // ori $8,$0,0x55
  localparam logic [31:0] SW7   = 32'hAC27_0004; // sw  $7,4($1)
  localparam logic [31:0] SYSC  = 32'h0000_000C; // syscall
  localparam logic [31:0] ILL   = 32'hFC22_1820; // opcode 0x3F

  // Expected control bits [18:4] (flags above ALU_OP)
  localparam logic [31:0] FL_ADD = 32'h0042;   // RegWrite, RegDst
  localparam logic [31:0] FL_LW  = 32'h0027;   // ALU_SRC, RegWrite, MemToReg, SignedExt
  localparam logic [31:0] FL_ORI = 32'h0003;   // ALU_SRC, RegWrite
  localparam logic [31:0] FL_SYS = 32'h4000;   // SysCALL

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Instr;
  logic        IfValid, BranchTaken, Go;

  logic        r3, h3, exv3, memv3, wbv3;
  logic [18:0] exc3, memc3, wbc3;
  logic [4:0]  wbd3;
  logic        r6, h6, exv6, memv6, wbv6;
  logic [18:0] exc6, memc6, wbc6;
  logic [4:0]  wbd6;

  int compared   = 0;
  int mismatched = 0;

  pipe_ctrl_unit #(.STAGES(3)) dut3 (
    .CLK(CLK), .RST(RST), .Instr(Instr), .IfValid(IfValid), .Ready(r3),
    .BranchTaken(BranchTaken), .Go(Go),
    .EX_Ctrl(exc3), .MEM_Ctrl(memc3), .WB_Ctrl(wbc3),
    .EX_Valid(exv3), .MEM_Valid(memv3), .WB_Valid(wbv3),
    .WB_Dst(wbd3), .Halted(h3)
  );

  pipe_ctrl_unit #(.STAGES(6)) dut6 (
    .CLK(CLK), .RST(RST), .Instr(Instr), .IfValid(IfValid), .Ready(r6),
    .BranchTaken(BranchTaken), .Go(Go),
    .EX_Ctrl(exc6), .MEM_Ctrl(memc6), .WB_Ctrl(wbc6),
    .EX_Valid(exv6), .MEM_Valid(memv6), .WB_Valid(wbv6),
    .WB_Dst(wbd6), .Halted(h6)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    RST = 1'b1; Instr = '0; IfValid = 1'b0; BranchTaken = 1'b0; Go = 1'b0;
    ticks(2);
    RST = 1'b0;

    check("rst_ready3", r3, 1);
    check("rst_halted3", h3, 0);
    check("rst_valids3", {exv3, memv3, wbv3}, 0);
    check("rst_ctrl3", {exc3, wbc3[12:0]} | memc3, 0);
    check("rst_wbdst3", wbd3, 0);
    check("rst_ready6", r6, 1);
    check("rst_valids6", {exv6, memv6, wbv6}, 0);
    tick();

    // single add, accepted at edge k
    Instr = ADD3; IfValid = 1'b1; tick(); IfValid = 1'b0;
    tick();
    check("add_ex_valid", exv3, 1);
    check("add_ex_flags", exc3[18:4], FL_ADD);
    tick();
    check("add_mem_valid", memv3, 1);
    tick();
    check("add_wb_valid", wbv3, 1);
    check("add_wb_dst", wbd3, 3);
    check("add_wb_flags", wbc3[18:4], FL_ADD);
    tick();
    check("add_wb_gone", wbv3, 0);

    // load-use stall
    Instr = LW5; IfValid = 1'b1; tick();
    Instr = ADD6; tick(); IfValid = 1'b0;
    check("lu_ready_low", r3, 0);
    check("lu_ex_lw", exc3[18:4], FL_LW);
    tick();
    check("lu_bubble", exv3, 0);
    check("lu_mem_lw", memv3, 1);
    check("lu_ready_back", r3, 1);
    tick();
    check("lu_add_in_ex", exv3, 1);
    check("lu_add_flags", exc3[18:4], FL_ADD);
    check("lu_wb_lw_dst", wbd3, 5);
    ticks(2);
    check("lu_wb_add_valid", wbv3, 1);
    check("lu_wb_add_dst", wbd3, 6);

    // I-type rt is not a source: no stall behind the load
    Instr = LW5; IfValid = 1'b1; tick();
    Instr = ORI5; tick(); IfValid = 1'b0;
    check("rt_nohaz_ready", r3, 1);
    tick();
    check("rt_nohaz_ex_valid", exv3, 1);
    check("rt_nohaz_ex_flags", exc3[18:4], FL_ORI);
    ticks(3);

    // flush kills sw in ID and discards the instruction on Instr
    Instr = SW7; IfValid = 1'b1; tick();
    BranchTaken = 1'b1; Instr = ORI8; tick(); BranchTaken = 1'b0;
    check("fl_sw_killed", exv3, 0);
    check("fl_ready", r3, 1);
    Instr = ADD3; tick(); IfValid = 1'b0;
    check("fl_ori_discarded", exv3, 0);
    tick();
    check("fl_next_ex_valid", exv3, 1);
    check("fl_next_ex_flags", exc3[18:4], FL_ADD);
    ticks(3);

    // hazard and flush in the same cycle
    Instr = LW5; IfValid = 1'b1; tick();
    Instr = ADD6; tick(); IfValid = 1'b0;
    check("hf_hazard_seen", r3, 0);
    BranchTaken = 1'b1; tick(); BranchTaken = 1'b0;
    check("hf_ex_empty", exv3, 0);
    check("hf_ready", r3, 1);
    tick();
    check("hf_add_gone", exv3, 0);
    check("hf_wb_lw", {wbv3, 3'b000, wbd3}, {1'b1, 3'b000, 5'd5});
    ticks(2);

    // SYSCALL drain/halt; ori held on Instr throughout
    RST = 1'b1; tick(); RST = 1'b0;
    Instr = SYSC; IfValid = 1'b1; tick();
    Instr = ORI8;
    check("sys_in_id_ready", r3, 0);
    tick();
    check("sys_ex_valid", exv3, 1);
    check("sys_ex_flags", exc3[18:4], FL_SYS);
    check("sys_drain_ready", r3, 0);
    ticks(2);
    check("sys_wb_valid", wbv3, 1);
    tick();
    check("sys_wb_dropped", wbv3, 0);
    check("sys_not_yet_halted", h3, 0);
    tick();
    check("sys_halted", h3, 1);
    check("sys_halt_ready", r3, 0);
    Go = 1'b1; tick(); Go = 1'b0;
    check("go_ready3", r3, 1);
    check("go_unhalted3", h3, 0);
    check("go_ignored_drain6", {h6, r6}, 0);
    tick(); IfValid = 1'b0;
    check("go_ori_in_id_ready", r3, 1);
    tick();
    check("go_ori_ex_valid", exv3, 1);
    check("go_ori_ex_flags", exc3[18:4], FL_ORI);
    check("go_halted6", h6, 1);
    check("go_ex_empty6", exv6, 0);

    // reset while draining
    RST = 1'b1; tick(); RST = 1'b0;
    Instr = SYSC; IfValid = 1'b1; tick(); IfValid = 1'b0;
    ticks(2);
    check("md_in_drain", {memv3, r3}, 2'b10);
    #2 RST = 1'b1;
    #1;
    check("md_valids_cleared", {exv3, memv3, wbv3}, 0);
    check("md_ready", r3, 1);
    check("md_halted", h3, 0);
    tick(); RST = 1'b0;
    tick();
    check("md_after_ready", r3, 1);

    // illegal opcode, latency for both depths
    Instr = ILL; IfValid = 1'b1; tick(); IfValid = 1'b0;
    tick();
    check("ill_ex_valid3", exv3, 1);
    check("ill_ex_ctrl3", exc3, 0);
    check("ill_ex_valid6", exv6, 1);
    ticks(2);
    check("ill_wb_valid3", wbv3, 1);
    check("ill_wb_ctrl3", wbc3, 0);
    check("ill_wb_early6", wbv6, 0);
    ticks(3);
    check("ill_wb_valid6", wbv6, 1);
    check("ill_wb_ctrl6", wbc6, 0);
    check("ill_wb_dst6", wbd6, 2);
    check("ill_wb_gone3", wbv3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
